// File: rtl/read_bpm_test_link_if.sv
// AXI stream carrying BPM test packets from the Aurora receiver into the
// checker. The master drives tdata/tvalid/tlast and the slave drives tready.
interface read_bpm_test_link_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/read_bpm_test_link.sv
// read_bpm_test_link: receive-side checker for four-word BPM test packets
// (header, X, Y, sum). Each FA session is closed by auroraFAstrobe, which
// reports one status code and restarts packet counting.
// Handshake: a beat transfers on any clock edge where tvalid and tready are
// both high; tdata/tlast are only looked at on such beats.
// Optional feature macro: BPM_TEST_BACKPRESSURE_EN drives tready from a
// 16-bit LFSR instead of holding it high.
module read_bpm_test_link #(
  parameter int BPM_COUNT_WIDTH = 6,
  parameter int ERR_COUNT_WIDTH = 16
) (
  input  logic                       auroraUserClk,
  input  logic                       auroraReset,
  input  logic                       auroraFAstrobe,
  read_bpm_test_link_if.slave        BPM_TEST_AXI_STREAM_RX,
  input  logic [BPM_COUNT_WIDTH-1:0] expBPMcount,
  input  logic [4:0]                 expCellIndex,
  output logic                       TESTstatusStrobe,
  output logic [1:0]                 TESTstatusCode,
  output logic [BPM_COUNT_WIDTH-1:0] packetCount,
  output logic [ERR_COUNT_WIDTH-1:0] errorCount,
  output logic [14:0]                lastFAcycle,
  output logic [2:0]                 dbgRxState
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_X       = 3'd2,
    ST_Y       = 3'd3,
    ST_SUM     = 3'd4,
    ST_DISCARD = 3'd5
  } rx_state_t;

  rx_state_t state, state_nxt;

  logic        ready_q;
  logic        beat;
  logic [31:0] d;
  logic [4:0]  idx;
  logic [14:0] cyc_next;

  // Session bookkeeping
  logic session_open;   // a strobe has been seen since reset
  logic have_prev;      // an earlier session captured a cycle number
  logic captured;       // this session captured its cycle number
  logic sess_content;
  logic sess_frame;
  logic pkt_bad;        // flags accumulated on the packet in progress

  // Combinational results for the current beat
  logic       word_err;
  logic       content_err_now;
  logic       frame_err_now;
  logic       complete;
  logic       pkt_bad_total;
  logic [1:0] sess_code;

  logic unused_cell_msb;
  assign unused_cell_msb = expCellIndex[4];

  assign d        = BPM_TEST_AXI_STREAM_RX.tdata;
  assign beat     = BPM_TEST_AXI_STREAM_RX.tvalid & ready_q;
  assign idx      = packetCount[4:0];
  assign cyc_next = lastFAcycle + 15'd1;
  assign dbgRxState = state;

`ifdef BPM_TEST_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        ready_en;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign ready_q = ready_en & lfsr[0];

  // LFSR advances every cycle to throttle the transmitter
  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      lfsr     <= 16'hACE1;
      ready_en <= 1'b0;
    end else begin
      lfsr     <= {lfsr[14:0], lfsr_fb};
      ready_en <= 1'b1;
    end
  end
`else
  // tready comes up one clock after reset and then stays high
  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) ready_q <= 1'b0;
    else             ready_q <= 1'b1;
  end
`endif

  assign BPM_TEST_AXI_STREAM_RX.tready = ready_q;

  // Expected-word comparison for the word the FSM is waiting for
  always_comb begin
    word_err = 1'b0;
    case (state)
      ST_HEADER: word_err = (d[31:16] != 16'hA5BE) || !d[15] || (d[14:9] != 6'd0) ||
                            (d[8:5] != expCellIndex[3:0]) || (d[4:0] != idx);
      ST_X:      word_err = (d != {16'hCAFE, 11'd0, idx});
      ST_Y:      word_err = (d != {16'hBEEF, 11'd0, idx});
      ST_SUM: begin
        word_err = d[31] || (d[15:0] != {11'd0, idx});
        if (packetCount == '0) begin
          if (have_prev && (d[30:16] != cyc_next)) word_err = 1'b1;
        end else if (d[30:16] != lastFAcycle) begin
          word_err = 1'b1;
        end
      end
      default:   word_err = 1'b0;
    endcase
  end

  // Next state, per-beat flags and the result of the session being closed
  always_comb begin
    state_nxt       = state;
    content_err_now = 1'b0;
    frame_err_now   = 1'b0;
    complete        = 1'b0;
    if (auroraFAstrobe) begin
      state_nxt = ST_HEADER;
    end else if (beat) begin
      case (state)
        ST_HEADER, ST_X, ST_Y: begin
          content_err_now = word_err;
          if (BPM_TEST_AXI_STREAM_RX.tlast) begin
            frame_err_now = 1'b1;
            complete      = 1'b1;
            state_nxt     = ST_HEADER;
          end else begin
            state_nxt = (state == ST_HEADER) ? ST_X : (state == ST_X) ? ST_Y : ST_SUM;
          end
        end
        ST_SUM: begin
          content_err_now = word_err;
          complete        = 1'b1;
          if (BPM_TEST_AXI_STREAM_RX.tlast) begin
            state_nxt = ST_HEADER;
          end else begin
            frame_err_now = 1'b1;
            state_nxt     = ST_DISCARD;
          end
        end
        ST_DISCARD: if (BPM_TEST_AXI_STREAM_RX.tlast) state_nxt = ST_HEADER;
        default:    state_nxt = state;
      endcase
    end
    pkt_bad_total = pkt_bad | content_err_now | frame_err_now;

    if (sess_frame || ((state != ST_HEADER) && (state != ST_IDLE))) sess_code = 2'd3;
    else if (sess_content)                                          sess_code = 2'd1;
    else if (packetCount != expBPMcount)                            sess_code = 2'd2;
    else                                                            sess_code = 2'd0;
  end

  // FSM state register
  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Counters, session flags and status reporting
  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      TESTstatusStrobe <= 1'b0;
      TESTstatusCode   <= 2'd0;
      packetCount      <= '0;
      errorCount       <= '0;
      lastFAcycle      <= '0;
      session_open     <= 1'b0;
      have_prev        <= 1'b0;
      captured         <= 1'b0;
      sess_content     <= 1'b0;
      sess_frame       <= 1'b0;
      pkt_bad          <= 1'b0;
    end else if (auroraFAstrobe) begin
      TESTstatusStrobe <= session_open;
      if (session_open) TESTstatusCode <= sess_code;
      session_open <= 1'b1;
      have_prev    <= have_prev | captured;
      captured     <= 1'b0;
      packetCount  <= '0;
      sess_content <= 1'b0;
      sess_frame   <= 1'b0;
      pkt_bad      <= 1'b0;
    end else begin
      TESTstatusStrobe <= 1'b0;
      if (content_err_now) sess_content <= 1'b1;
      if (frame_err_now)   sess_frame   <= 1'b1;
      if (beat && (state == ST_SUM) && (packetCount == '0)) begin
        lastFAcycle <= d[30:16];
        captured    <= 1'b1;
      end
      if (complete) begin
        pkt_bad <= 1'b0;
        if (packetCount != '1) packetCount <= packetCount + 1'b1;
        if (pkt_bad_total && (errorCount != '1)) errorCount <= errorCount + 1'b1;
      end else begin
        pkt_bad <= pkt_bad_total;
      end
    end
  end

endmodule

// File: tb/tb_read_bpm_test_link.sv
// tb_read_bpm_test_link: directed sessions of BPM test packets; expected
// status codes are queued when a closing strobe is driven and compared when
// TESTstatusStrobe appears.
module tb_read_bpm_test_link;

  logic        clk;
  logic        rst;
  logic        fa_strobe;
  logic [5:0]  exp_count;
  logic [4:0]  exp_cell;
  logic        status_strobe;
  logic [1:0]  status_code;
  logic [5:0]  packet_count;
  logic [15:0] error_count;
  logic [14:0] last_fa_cycle;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  read_bpm_test_link_if rx_if ();

  read_bpm_test_link #(.BPM_COUNT_WIDTH(6), .ERR_COUNT_WIDTH(16)) dut (
    .auroraUserClk          (clk),
    .auroraReset            (rst),
    .auroraFAstrobe         (fa_strobe),
    .BPM_TEST_AXI_STREAM_RX (rx_if),
    .expBPMcount            (exp_count),
    .expCellIndex           (exp_cell),
    .TESTstatusStrobe       (status_strobe),
    .TESTstatusCode         (status_code),
    .packetCount            (packet_count),
    .errorCount             (error_count),
    .lastFAcycle            (last_fa_cycle),
    .dbgRxState             (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Status monitor: every strobe must match the oldest queued code
  always @(negedge clk) begin
    if (status_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_status_strobe", {30'd0, status_code}, 32'hFFFF_FFFF);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("status_code", {30'd0, status_code}, {30'd0, e});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [31:0] data, input logic last);
    int n;
    n = 0;
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = data;
    rx_if.tlast  = last;
    while (rx_if.tready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("tready_timeout", {31'd0, rx_if.tready}, 32'd1);
    tick();
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
  endtask

  task automatic send_packet(input int idx, input logic [14:0] cyc,
                             input logic bad_x, input logic early_last);
    logic [4:0]  i;
    logic [31:0] x;
    i = idx[4:0];
    x = bad_x ? 32'hCAFE0004 : {16'hCAFE, 11'd0, i};
    put_word({16'hA5BE, 1'b1, 6'd0, exp_cell[3:0], i}, 1'b0);
    put_word(x, 1'b0);
    put_word({16'hBEEF, 11'd0, i}, early_last);
    if (!early_last) put_word({1'b0, cyc, 11'd0, i}, 1'b1);
  endtask

  task automatic send_session(input int n, input logic [14:0] cyc,
                              input int bad_x_pkt, input int early_pkt);
    for (int p = 0; p < n; p++) send_packet(p, cyc, p == bad_x_pkt, p == early_pkt);
  endtask

  task automatic do_strobe(input logic expect_status, input logic [1:0] code);
    if (expect_status) exp_q.push_back(code);
    fa_strobe = 1'b1;
    tick();
    fa_strobe = 1'b0;
    tick();
    tick();
    check("status_pending", exp_q.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, {31'd0, rx_if.tready}, 32'd0);
    check({tag, "_strobe"}, {31'd0, status_strobe}, 32'd0);
    check({tag, "_code"}, {30'd0, status_code}, 32'd0);
    check({tag, "_packet_count"}, {26'd0, packet_count}, 32'd0);
    check({tag, "_error_count"}, {16'd0, error_count}, 32'd0);
    check({tag, "_last_fa_cycle"}, {17'd0, last_fa_cycle}, 32'd0);
    check({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
  endtask

  task automatic do_reset;
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
    fa_strobe    = 1'b0;
    rst          = 1'b1;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    check("tready_during_release", {31'd0, rx_if.tready}, 32'd0);
    tick();
`ifndef BPM_TEST_BACKPRESSURE_EN
    check("tready_after_reset", {31'd0, rx_if.tready}, 32'd1);
`endif
  endtask

  initial begin
    rst          = 1'b1;
    fa_strobe    = 1'b0;
    exp_count    = 6'd16;
    exp_cell     = 5'd12;
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
    rx_if.tdata  = 32'd0;

    // Clean session: no status at the first strobe, code 0 at the second
    do_reset();
    check("idle_state", {29'd0, dbg_state}, 32'd0);
    do_strobe(1'b0, 2'd0);
    check("header_state", {29'd0, dbg_state}, 32'd1);
    send_session(16, 15'h0005, -1, -1);
    check("clean_packet_count", {26'd0, packet_count}, 32'd16);
    check("clean_error_count", {16'd0, error_count}, 32'd0);
    check("clean_last_fa_cycle", {17'd0, last_fa_cycle}, 32'h0005);
    do_strobe(1'b1, 2'd0);
    check("packet_count_cleared", {26'd0, packet_count}, 32'd0);

    // Bad X word on packet 5 -> content mismatch
    do_reset();
    do_strobe(1'b0, 2'd0);
    send_session(16, 15'h0005, 5, -1);
    check("content_error_count", {16'd0, error_count}, 32'd1);
    do_strobe(1'b1, 2'd1);

    // One packet short -> count mismatch
    do_reset();
    do_strobe(1'b0, 2'd0);
    send_session(15, 15'h0005, -1, -1);
    check("short_packet_count", {26'd0, packet_count}, 32'd15);
    check("short_error_count", {16'd0, error_count}, 32'd0);
    do_strobe(1'b1, 2'd2);

    // Early tlast on the Y word of packet 2 -> framing
    do_reset();
    do_strobe(1'b0, 2'd0);
    send_session(2, 15'h0005, -1, -1);
    send_packet(2, 15'h0005, 1'b0, 1'b1);
    check("early_last_state", {29'd0, dbg_state}, 32'd1);
    check("early_last_packet_count", {26'd0, packet_count}, 32'd3);
    for (int p = 3; p < 16; p++) send_packet(p, 15'h0005, 1'b0, 1'b0);
    check("framing_packet_count", {26'd0, packet_count}, 32'd16);
    check("framing_error_count", {16'd0, error_count}, 32'd1);
    do_strobe(1'b1, 2'd3);

    // Cycle continuity: 1 then 3 is a gap, 3 then 4 is fine
    exp_count = 6'd4;
    do_reset();
    do_strobe(1'b0, 2'd0);
    send_session(4, 15'h0001, -1, -1);
    do_strobe(1'b1, 2'd0);
    send_session(4, 15'h0003, -1, -1);
    check("gap_error_count", {16'd0, error_count}, 32'd1);
    check("gap_last_fa_cycle", {17'd0, last_fa_cycle}, 32'h0003);
    do_strobe(1'b1, 2'd1);
    send_session(2, 15'h0004, -1, -1);
    check("continue_error_count", {16'd0, error_count}, 32'd1);
    check("continue_last_fa_cycle", {17'd0, last_fa_cycle}, 32'h0004);

    // Reset in the middle of packet 2's X word
    put_word({16'hA5BE, 1'b1, 6'd0, exp_cell[3:0], 5'd2}, 1'b0);
    check("mid_packet_state", {29'd0, dbg_state}, 32'd2);
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = {16'hCAFE, 11'd0, 5'd2};
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    rx_if.tvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_strobe(1'b0, 2'd0);

    // Cycle number wrap from 0x7FFF to 0x0000
    send_session(4, 15'h7FFF, -1, -1);
    do_strobe(1'b1, 2'd0);
    send_session(4, 15'h0000, -1, -1);
    check("wrap_last_fa_cycle", {17'd0, last_fa_cycle}, 32'h0000);
    check("wrap_error_count", {16'd0, error_count}, 32'd0);
    do_strobe(1'b1, 2'd0);

    tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
